iter_decoder_core: RTL and testbench

//  Sequential min-sum decoding engine. Reuses one interm_layer instance over
//  up to N_ITER clocked iterations, with per-iteration bias selection.

---
 rtl/iter_decoder_core.sv | 193 +++++++++++++++++++
 tb/tb_iter_decoder_core.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_decoder_core.sv
// Iterative offset min-sum decoder: one shared check/variable update
// layer reused across iterations, with optional stop on convergence.

module interm_layer #(
  parameter int WIDTH         = 6,
  parameter int N_V           = 7,
  parameter int E             = 12,
  parameter int EXTENDED_BITS = 2,
  parameter int IDX_W         = 8
) (
  input  logic [WIDTH*N_V-1:0] all_llrs_i,
  input  logic [WIDTH*E-1:0]   prev_proc_elem_i,
  input  logic [IDX_W-1:0]     bias_idx_i,
  output logic [WIDTH*E-1:0]   proc_elem_o
);

  localparam int IW   = WIDTH + EXTENDED_BITS;
  localparam int QMAX = (1 << (IW - 1)) - 1;
  localparam int QMIN = -(1 << (IW - 1));
  localparam int RMAX = (1 << (WIDTH - 1)) - 1;
  localparam int DEG  = 4;
  // Edge e joins check e/DEG to variable EV[e] (Hamming(7,4) checks).
  localparam int EV [12] = '{0, 1, 2, 4, 0, 1, 3, 5, 0, 2, 3, 6};

  function automatic int bias_lut(logic [IDX_W-1:0] idx);
    int b;
    case (idx)
      IDX_W'(0): b = 2;
      IDX_W'(1): b = 1;
      default:   b = 0;
    endcase
    return b;
  endfunction

  int q [E];
  int bias;

  always_comb begin
    bias = bias_lut(bias_idx_i);
    for (int e = 0; e < E; e++) begin
      q[e] = int'($signed(all_llrs_i[EV[e]*WIDTH +: WIDTH]));
      for (int j = 0; j < E; j++) begin
        if (j != e && EV[j] == EV[e]) begin
          q[e] += int'($signed(prev_proc_elem_i[j*WIDTH +: WIDTH]));
        end
      end
      if (q[e] > QMAX) q[e] = QMAX;
      if (q[e] < QMIN) q[e] = QMIN;
    end
  end

  always_comb begin
    proc_elem_o = '0;
    for (int e = 0; e < E; e++) begin
      int   mn;
      int   r;
      logic sg;
      mn = QMAX + 1;
      sg = 1'b0;
      r  = 0;
      for (int j = 0; j < E; j++) begin
        if (j != e && (j / DEG) == (e / DEG)) begin
          sg = sg ^ (q[j] < 0);
          if ((q[j] < 0 ? -q[j] : q[j]) < mn) begin
            mn = q[j] < 0 ? -q[j] : q[j];
          end
        end
      end
      mn = mn - bias;
      if (mn < 0)    mn = 0;
      if (mn > RMAX) mn = RMAX;
      r = sg ? -mn : mn;
      proc_elem_o[e*WIDTH +: WIDTH] = r[WIDTH-1:0];
    end
  end

endmodule

module iter_decoder_core #(
  parameter int WIDTH         = 6,
  parameter int N_V           = 7,
  parameter int E             = 12,
  parameter int EXTENDED_BITS = 2,
  parameter int N_ITER        = 5,
  parameter int EARLY_STOP    = 1,
  localparam int ITER_W       = $clog2(N_ITER + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*N_V-1:0] in_llrs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH*E-1:0]   out_proc_elem,
  output logic [WIDTH*N_V-1:0] out_llrs,
  output logic [ITER_W-1:0]    out_iters,
  output logic                 out_converged
);

  localparam int INT_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH*N_V-1:0]   llr_q, llr_d;
  logic [WIDTH*E-1:0]     pe_q, pe_d;
  logic [ITER_W-1:0]      iter_q, iter_d;
  logic                   conv_q, conv_d;
  logic [WIDTH*E-1:0]     proc_elem;
  logic [INT_SIZE-1:0]    bias_idx;
  logic                   stop_max;
  logic                   stop_conv;

  assign bias_idx = {{(INT_SIZE - ITER_W){1'b0}}, iter_q};

  interm_layer #(
    .WIDTH         (WIDTH),
    .N_V           (N_V),
    .E             (E),
    .EXTENDED_BITS (EXTENDED_BITS),
    .IDX_W         (INT_SIZE)
  ) u_layer (
    .all_llrs_i       (llr_q),
    .prev_proc_elem_i (pe_q),
    .bias_idx_i       (bias_idx),
    .proc_elem_o      (proc_elem)
  );

  // Iteration 0 is never a convergence candidate: pe_q is still all-zero.
  assign stop_max  = (iter_q == ITER_W'(N_ITER - 1));
  assign stop_conv = (EARLY_STOP != 0) && (iter_q != '0)
                   && (proc_elem == pe_q);

  always_comb begin
    state_d = state_q;
    llr_d   = llr_q;
    pe_d    = pe_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          llr_d   = in_llrs;
          pe_d    = '0;
          iter_d  = '0;
          conv_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        pe_d   = proc_elem;
        iter_d = iter_q + 1'b1;
        if (stop_max || stop_conv) begin
          state_d = DONE;
          conv_d  = stop_conv;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      llr_q   <= '0;
      pe_q    <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      llr_q   <= llr_d;
      pe_q    <= pe_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_proc_elem = pe_q;
  assign out_llrs      = llr_q;
  assign out_iters     = iter_q;
  assign out_converged = conv_q;

endmodule

// File: tb/tb_iter_decoder_core.sv
// Bench for iter_decoder_core: two instances (early stop on/off) sharing
// one stimulus path, checked against a matrix-level min-sum model.

module tb_iter_decoder_core;

  localparam int W  = 6;
  localparam int NV = 7;
  localparam int E  = 12;
  localparam int NI = 5;
  localparam int LW = W * NV;
  localparam int PW = W * E;

  // Parity-check rows: variables touched by each check, edge = c*4+k.
  localparam int CV [3][4] = '{'{0, 1, 2, 4}, '{0, 1, 3, 5}, '{0, 2, 3, 6}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, out_ready, sel;
  logic [LW-1:0] in_llrs;

  logic          es_in_ready, es_out_valid, es_conv;
  logic [PW-1:0] es_pe;
  logic [LW-1:0] es_llrs;
  logic [2:0]    es_iters;
  logic          ne_in_ready, ne_out_valid, ne_conv;
  logic [PW-1:0] ne_pe;
  logic [LW-1:0] ne_llrs;
  logic [2:0]    ne_iters;

  logic          in_valid_es, in_valid_ne;
  logic          in_ready_m, out_valid_m, out_conv_m;
  logic [PW-1:0] out_pe_m;
  logic [LW-1:0] out_llrs_m;
  logic [2:0]    out_iters_m;

  assign in_valid_es = in_valid & ~sel;
  assign in_valid_ne = in_valid & sel;
  assign in_ready_m  = sel ? ne_in_ready  : es_in_ready;
  assign out_valid_m = sel ? ne_out_valid : es_out_valid;
  assign out_conv_m  = sel ? ne_conv      : es_conv;
  assign out_pe_m    = sel ? ne_pe        : es_pe;
  assign out_llrs_m  = sel ? ne_llrs      : es_llrs;
  assign out_iters_m = sel ? ne_iters     : es_iters;

  iter_decoder_core #(.N_ITER(NI), .EARLY_STOP(1)) dut_es (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid_es),
    .in_ready      (es_in_ready),
    .in_llrs       (in_llrs),
    .out_valid     (es_out_valid),
    .out_ready     (out_ready),
    .out_proc_elem (es_pe),
    .out_llrs      (es_llrs),
    .out_iters     (es_iters),
    .out_converged (es_conv)
  );

  iter_decoder_core #(.N_ITER(NI), .EARLY_STOP(0)) dut_ne (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid_ne),
    .in_ready      (ne_in_ready),
    .in_llrs       (in_llrs),
    .out_valid     (ne_out_valid),
    .out_ready     (out_ready),
    .out_proc_elem (ne_pe),
    .out_llrs      (ne_llrs),
    .out_iters     (ne_iters),
    .out_converged (ne_conv)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit   rand_rdy  = 1'b0;
  logic rdy_force = 1'b1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  typedef struct {
    logic [PW-1:0] pe;
    logic [LW-1:0] llr;
    int            it;
    bit            cv;
    int            acc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Offset min-sum on the parity-check matrix: variable totals minus own
  // edge give extrinsic messages, then sign product and min per check.
  task automatic model(input logic [LW-1:0] l, input bit es,
                       output exp_t r);
    int L [NV];
    int tot [NV];
    int R [E];
    int Rn [E];
    int q [4];
    int bias, mn, m;
    bit s, same, done;
    for (int v = 0; v < NV; v++) L[v] = int'($signed(l[v*W +: W]));
    for (int e = 0; e < E; e++) R[e] = 0;
    r.it  = 0;
    r.cv  = 1'b0;
    r.acc = 0;
    done  = 1'b0;
    for (int it = 0; it < NI && !done; it++) begin
      bias = (it == 0) ? 2 : (it == 1) ? 1 : 0;
      for (int v = 0; v < NV; v++) tot[v] = L[v];
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < 4; k++) tot[CV[c][k]] += R[c*4+k];
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < 4; k++) begin
          q[k] = tot[CV[c][k]] - R[c*4+k];
          if (q[k] > 127)  q[k] = 127;
          if (q[k] < -128) q[k] = -128;
        end
        for (int k = 0; k < 4; k++) begin
          s  = 1'b0;
          mn = 1000;
          for (int j = 0; j < 4; j++) begin
            if (j != k) begin
              s ^= (q[j] < 0);
              m  = (q[j] < 0) ? -q[j] : q[j];
              if (m < mn) mn = m;
            end
          end
          mn = mn - bias;
          if (mn < 0)  mn = 0;
          if (mn > 31) mn = 31;
          Rn[c*4+k] = s ? -mn : mn;
        end
      end
      same = 1'b1;
      for (int e = 0; e < E; e++) if (Rn[e] != R[e]) same = 1'b0;
      for (int e = 0; e < E; e++) R[e] = Rn[e];
      r.it = it + 1;
      if (es && it >= 1 && same) begin
        r.cv = 1'b1;
        done = 1'b1;
      end
    end
    for (int e = 0; e < E; e++) r.pe[e*W +: W] = W'(R[e]);
    r.llr = l;
  endtask

  // Scoreboard compare: every cycle a result is held, plus latency.
  initial begin
    exp_t x;
    bit   first;
    first = 1'b1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        sb.delete();
        first = 1'b1;
      end else begin
        if (out_valid_m === 1'b1) begin
          if (sb.size() == 0) begin
            chk("spurious_out_valid", PW'(out_valid_m), PW'(0));
          end else begin
            chk("pe", out_pe_m, sb[0].pe);
            chk("llrs", PW'(out_llrs_m), PW'(sb[0].llr));
            chk("iters", PW'(out_iters_m), PW'(sb[0].it));
            chk("conv", PW'(out_conv_m), PW'(sb[0].cv));
            chk("in_ready_busy", PW'(in_ready_m), PW'(0));
            if (first) begin
              chk("latency", PW'(cyc - sb[0].acc), PW'(sb[0].it));
              first = 1'b0;
            end
            if (out_ready === 1'b1) begin
              void'(sb.pop_front());
              first = 1'b1;
            end
          end
        end
        if (in_valid === 1'b1 && in_ready_m === 1'b1) begin
          model(in_llrs, !sel, x);
          x.acc = cyc + 1;
          sb.push_back(x);
        end
      end
    end
  end

  task automatic send(input logic [LW-1:0] l);
    int n;
    n = 0;
    in_llrs  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready_m !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", PW'(in_ready_m), PW'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid_m !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", PW'(out_valid_m), PW'(1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", PW'(sb.size()), PW'(0));
  endtask

  function automatic logic [LW-1:0] rnd_frame();
    logic [LW-1:0] f;
    for (int v = 0; v < NV; v++) f[v*W +: W] = W'($urandom_range(0, 63));
    return f;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] f, f2, ten;
    logic [PW-1:0] pexp;
    int            pv [4];
    int            gap;
    pv = '{10, 10, 10, 20};
    for (int v = 0; v < NV; v++) ten[v*W +: W] = W'(10);
    for (int e = 0; e < E; e++) pexp[e*W +: W] = W'(pv[e % 4]);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_llrs  = '0;
    sel      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", PW'(in_ready_m), PW'(1));
    chk("rst_out_valid", PW'(out_valid_m), PW'(0));
    chk("rst_iters", PW'(out_iters_m), PW'(0));
    chk("rst_pe", out_pe_m, PW'(0));
    chk("rst_llrs", PW'(out_llrs_m), PW'(0));
    chk("rst_conv", PW'(out_conv_m), PW'(0));
    step();

    // All-zero frame converges after two iterations
    send('0);
    wait_out();
    chk("zero_iters", PW'(out_iters_m), PW'(2));
    chk("zero_conv", PW'(out_conv_m), PW'(1));
    chk("zero_pe", out_pe_m, PW'(0));
    step();

    // All +10: converges exactly at the last iteration
    send(ten);
    wait_out();
    chk("ten_es_pe", out_pe_m, pexp);
    chk("ten_es_iters", PW'(out_iters_m), PW'(5));
    chk("ten_es_conv", PW'(out_conv_m), PW'(1));
    step();
    sel = 1'b1;
    send(ten);
    wait_out();
    chk("ten_ne_pe", out_pe_m, pexp);
    chk("ten_ne_iters", PW'(out_iters_m), PW'(5));
    chk("ten_ne_conv", PW'(out_conv_m), PW'(0));
    step();
    for (int i = 0; i < 3; i++) begin
      send(rnd_frame());
      wait_out();
      chk("ne_rand_iters", PW'(out_iters_m), PW'(5));
      chk("ne_rand_conv", PW'(out_conv_m), PW'(0));
      step();
    end

    // Backpressure with a pending frame
    sel       = 1'b0;
    rdy_force = 1'b0;
    f  = rnd_frame();
    f2 = rnd_frame();
    step();
    send(f);
    wait_out();
    step();
    in_llrs  = f2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", PW'(in_ready_m), PW'(0));
      chk("bp_out_valid", PW'(out_valid_m), PW'(1));
    end
    step();
    rdy_force = 1'b1;
    @(negedge clk);
    chk("bp_last_hold", PW'(out_valid_m), PW'(1));
    @(negedge clk);
    chk("bp_release_valid", PW'(out_valid_m), PW'(0));
    chk("bp_release_ready", PW'(in_ready_m), PW'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_pending_taken", PW'(in_ready_m), PW'(0));
    wait_out();
    step();

    // Reset while iter==2, then the same frame from a clean start
    sel = 1'b1;
    step();
    f = rnd_frame();
    send(f);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_in_ready", PW'(in_ready_m), PW'(1));
    chk("mid_out_valid", PW'(out_valid_m), PW'(0));
    chk("mid_iters", PW'(out_iters_m), PW'(0));
    chk("mid_pe", out_pe_m, PW'(0));
    chk("mid_llrs", PW'(out_llrs_m), PW'(0));
    chk("mid_conv", PW'(out_conv_m), PW'(0));
    step();
    send(f);
    wait_out();
    chk("mid_rerun_iters", PW'(out_iters_m), PW'(5));
    step();

    // Random frames on both instances with random gaps and out_ready
    for (int blk = 0; blk < 2; blk++) begin
      drain();
      sel      = blk[0] ? 1'b0 : 1'b1;
      rand_rdy = 1'b1;
      for (int i = 0; i < 500; i++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) step();
        send(rnd_frame());
      end
      rand_rdy = 1'b0;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
